// File: rtl/ctrl_pkg.sv
// Purpose: shared types and select encodings for the multicycle RV32I control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

   // FSM states of the multicycle sequencer
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      LUI      = 4'd11,
      TRAP     = 4'd12
   } state_t;

   // Major opcodes recognised by DECODE
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ALU operation codes
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_ctrl_t;

   // ALU operand A sources
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B sources
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus sources
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Purpose: maps funct3/funct7 (and op bit 5 for R vs I type) to an ALU operation.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic       op_b5,
   input  logic [2:0] funct3,
   input  logic       funct7,
   output logic [3:0] alu_ctrl
);

   // funct3 selects the operation; funct7 picks SUB/SRA, but SUB only for R-type
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (funct3)
         3'b000:  alu_ctrl = (op_b5 & funct7) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_ctrl = ALU_SLL;
         3'b010:  alu_ctrl = ALU_SLT;
         3'b011:  alu_ctrl = ALU_SLTU;
         3'b100:  alu_ctrl = ALU_XOR;
         3'b101:  alu_ctrl = funct7 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_ctrl = ALU_OR;
         default: alu_ctrl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: FSM sequencer for the multicycle RV32I datapath (optional MULTICYCLE_MEM_WAIT_EN memory wait).
// Latency: branch 3, R/I/store/JAL/LUI 4, load 5 cycles (plus memory wait cycles when enabled).
// Backpressure: with MULTICYCLE_MEM_WAIT_EN, FETCH/MEMREAD/MEMWRITE hold until mem_ready_i.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W   = 4,
   parameter int MEM_WAIT_MAX = 15
)(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [6:0]            op_i,
   input  logic [2:0]            funct3_i,
   input  logic                  funct7_i,
   input  logic                  Zero_i,
   input  logic                  LT_i,
   input  logic                  LTU_i,
   input  logic                  mem_ready_i,
   output logic                  PCWrite_o,
   output logic                  AdrSrc_o,
   output logic                  IRWrite_o,
   output logic                  MemWrite_o,
   output logic                  RegWrite_o,
   output logic [1:0]            ALUSrcA_o,
   output logic [1:0]            ALUSrcB_o,
   output logic [1:0]            ResultSrc_o,
   output logic [2:0]            ImmSrc_o,
   output logic [ALU_CTRL_W-1:0] ALUControl_o,
   output logic                  illegal_o,
   output logic                  mem_err_o
);

   localparam int WAIT_CNT_W = ($clog2(MEM_WAIT_MAX + 1) > 4) ? $clog2(MEM_WAIT_MAX + 1) : 4;

   if (ALU_CTRL_W < 4) begin : g_bad_alu_w
      $error("ALU_CTRL_W must be at least 4");
   end

   state_t     state, state_nxt;
   logic       illegal_q;
   logic       mem_ok;
   logic       mem_tmo;
   logic [3:0] alu_dec;

   logic       pc_wr, adr_src, ir_wr, mem_wr, reg_wr;
   logic [1:0] src_a, src_b, res_src;
   logic [2:0] imm_src;
   logic [3:0] alu_op;

   alu_decoder u_alu_decoder (
      .op_b5    (op_i[5]),
      .funct3   (funct3_i),
      .funct7   (funct7_i),
      .alu_ctrl (alu_dec)
   );

`ifdef MULTICYCLE_MEM_WAIT_EN
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  mem_err_q;
   logic                  in_mem_state;

   assign in_mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   assign mem_ok       = mem_ready_i;
   assign mem_tmo      = in_mem_state && !mem_ready_i &&
                         (wait_cnt == WAIT_CNT_W'(MEM_WAIT_MAX - 1));
   assign mem_err_o    = mem_err_q;

   // Wait counter restarts on every state change and counts stalled cycles
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wait_cnt  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         if (state_nxt != state) wait_cnt <= '0;
         else if (in_mem_state)  wait_cnt <= wait_cnt + 1'b1;
         if (mem_tmo) mem_err_q <= 1'b1;
      end
   end
`else
   logic [WAIT_CNT_W-1:0] unused_wait_lim;
   logic                  unused_mem_ready;

   assign unused_wait_lim  = WAIT_CNT_W'(MEM_WAIT_MAX);
   assign unused_mem_ready = mem_ready_i;
   assign mem_ok           = 1'b1;
   assign mem_tmo          = 1'b0;
   assign mem_err_o        = 1'b0;
`endif

   // State register and sticky illegal flag (set whenever TRAP is entered)
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         illegal_q <= illegal_q | (state_nxt == TRAP);
      end
   end

   // Next-state and Moore output decode; PCWrite in BRANCH depends on the flags
   always_comb begin
      state_nxt = state;
      pc_wr     = 1'b0;
      adr_src   = 1'b0;
      ir_wr     = 1'b0;
      mem_wr    = 1'b0;
      reg_wr    = 1'b0;
      src_a     = SRCA_PC;
      src_b     = SRCB_RS2;
      res_src   = RES_ALUOUT;
      imm_src   = IMM_I;
      alu_op    = ALU_ADD;
      case (state)
         FETCH: begin
            src_b   = SRCB_FOUR;
            res_src = RES_ALURES;
            ir_wr   = mem_ok;
            pc_wr   = mem_ok;
            if (mem_ok)       state_nxt = DECODE;
            else if (mem_tmo) state_nxt = TRAP;
         end
         DECODE: begin
            src_a   = SRCA_OLDPC;
            src_b   = SRCB_IMM;
            imm_src = IMM_B;
            case (op_i)
               OP_LOAD, OP_STORE: state_nxt = MEMADR;
               OP_RTYPE:          state_nxt = EXECR;
               OP_ITYPE:          state_nxt = EXECI;
               OP_BRANCH:         state_nxt = BRANCH;
               OP_JAL:            state_nxt = JAL;
               OP_LUI:            state_nxt = LUI;
               default:           state_nxt = TRAP;
            endcase
         end
         MEMADR: begin
            src_a     = SRCA_RS1;
            src_b     = SRCB_IMM;
            imm_src   = op_i[5] ? IMM_S : IMM_I;
            state_nxt = op_i[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ok)       state_nxt = MEMWB;
            else if (mem_tmo) state_nxt = TRAP;
         end
         MEMWB: begin
            res_src   = RES_RDATA;
            reg_wr    = 1'b1;
            state_nxt = FETCH;
         end
         MEMWRITE: begin
            adr_src = 1'b1;
            mem_wr  = 1'b1;
            if (mem_ok)       state_nxt = FETCH;
            else if (mem_tmo) state_nxt = TRAP;
         end
         EXECR: begin
            src_a     = SRCA_RS1;
            src_b     = SRCB_RS2;
            alu_op    = alu_dec;
            state_nxt = ALUWB;
         end
         EXECI: begin
            src_a     = SRCA_RS1;
            src_b     = SRCB_IMM;
            imm_src   = IMM_I;
            alu_op    = alu_dec;
            state_nxt = ALUWB;
         end
         ALUWB: begin
            res_src   = RES_ALUOUT;
            reg_wr    = 1'b1;
            state_nxt = FETCH;
         end
         BRANCH: begin
            src_a     = SRCA_RS1;
            src_b     = SRCB_RS2;
            alu_op    = ALU_SUB;
            res_src   = RES_ALUOUT;
            state_nxt = FETCH;
            case (funct3_i)
               3'b000:  pc_wr = Zero_i;
               3'b001:  pc_wr = !Zero_i;
               3'b100:  pc_wr = LT_i;
               3'b101:  pc_wr = !LT_i;
               3'b110:  pc_wr = LTU_i;
               3'b111:  pc_wr = !LTU_i;
               default: state_nxt = TRAP;
            endcase
         end
         JAL: begin
            src_a     = SRCA_OLDPC;
            src_b     = SRCB_FOUR;
            res_src   = RES_ALUOUT;
            pc_wr     = 1'b1;
            state_nxt = ALUWB;
         end
         LUI: begin
            src_a     = SRCA_ZERO;
            src_b     = SRCB_IMM;
            imm_src   = IMM_U;
            state_nxt = ALUWB;
         end
         TRAP: begin
            state_nxt = TRAP;
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   // Architectural enables are held off for as long as reset is asserted
   assign PCWrite_o    = pc_wr  & rst_n_i;
   assign IRWrite_o    = ir_wr  & rst_n_i;
   assign MemWrite_o   = mem_wr & rst_n_i;
   assign RegWrite_o   = reg_wr & rst_n_i;
   assign AdrSrc_o     = adr_src;
   assign ALUSrcA_o    = src_a;
   assign ALUSrcB_o    = src_b;
   assign ResultSrc_o  = res_src;
   assign ImmSrc_o     = imm_src;
   assign ALUControl_o = ALU_CTRL_W'(alu_op);
   assign illegal_o    = illegal_q;

endmodule
